// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator (pixel divider, h/v phase FSMs, registered syncs, frame counter)
module vga_sync_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clk,
   input  logic        reset,
   output logic        p_tick,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_tick,
   output logic [15:0] frame_count
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_ACT_END = 10'(H_DISPLAY - 1);
   localparam logic [9:0] H_FP_END  = 10'(H_DISPLAY + H_FRONT - 1);
   localparam logic [9:0] H_SY_END  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_END = 10'(V_DISPLAY - 1);
   localparam logic [9:0] V_FP_END  = 10'(V_DISPLAY + V_FRONT - 1);
   localparam logic [9:0] V_SY_END  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_e;

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic [15:0]   frame_count_q, frame_count_d;
   phase_e        h_q, h_d, v_q, v_d;
   logic          video_on_q, hsync_q, vsync_q;
   logic          line_end;

   // Next-state: divider, counters and phase FSMs; transitions are keyed on the
   // position so a reset anywhere always resynchronises the phases.
   always_comb begin
      p_tick        = div_q == DIV_LAST;
      line_end      = p_tick && x_q == H_LAST;
      frame_tick    = line_end && y_q == V_LAST;
      div_d         = p_tick ? '0 : div_q + 1'b1;
      x_d           = !p_tick ? x_q : line_end ? '0 : x_q + 10'd1;
      y_d           = !line_end ? y_q : frame_tick ? '0 : y_q + 10'd1;
      frame_count_d = frame_tick ? frame_count_q + 16'd1 : frame_count_q;
      h_d = !p_tick ? h_q :
            x_q == H_LAST    ? ACTIVE :
            x_q == H_ACT_END ? FRONT  :
            x_q == H_FP_END  ? SYNC   :
            x_q == H_SY_END  ? BACK   : h_q;
      v_d = !line_end ? v_q :
            y_q == V_LAST    ? ACTIVE :
            y_q == V_ACT_END ? FRONT  :
            y_q == V_FP_END  ? SYNC   :
            y_q == V_SY_END  ? BACK   : v_q;
   end

   // State registers; sync/enable outputs are decoded from next-state so they
   // move on the same edge as x/y.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         frame_count_q <= '0;
         h_q           <= ACTIVE;
         v_q           <= ACTIVE;
         video_on_q    <= 1'b1;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
      end else begin
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_count_q <= frame_count_d;
         h_q           <= h_d;
         v_q           <= v_d;
         video_on_q    <= h_d == ACTIVE && v_d == ACTIVE;
         hsync_q       <= h_d != SYNC;
         vsync_q       <= v_d != SYNC;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign video_on    = video_on_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_count = frame_count_q;
endmodule
